// File: rtl/bp_fe_ras_ckpt.sv
// Return-address stack: circular buffer with a top-of-stack pointer, a saturating
// occupancy count, same-cycle push+pop (replace top), overflow/underflow pulses,
// and a checkpoint/restore port for misprediction recovery.
module bp_fe_ras_ckpt #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned els_p         = 8,
  localparam int unsigned ptr_width_lp  = $clog2(els_p),
  localparam int unsigned cnt_width_lp  = $clog2(els_p + 1),
  localparam int unsigned ckpt_width_lp = ptr_width_lp + cnt_width_lp + vaddr_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [vaddr_width_p-1:0] push_addr_i,
  input  logic                     restore_v_i,
  input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
  output logic [vaddr_width_p-1:0] top_addr_o,
  output logic                     top_v_o,
  output logic [cnt_width_lp-1:0]  count_o,
  output logic [ckpt_width_lp-1:0] ckpt_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  // Registered state
  logic [vaddr_width_p-1:0] mem_r [els_p];
  logic [ptr_width_lp-1:0]  tos_r;
  logic [cnt_width_lp-1:0]  count_r;
  logic                     overflow_r;
  logic                     underflow_r;

  // Next-state / write-port controls
  logic [ptr_width_lp-1:0]  tos_n;
  logic [cnt_width_lp-1:0]  count_n;
  logic                     overflow_n;
  logic                     underflow_n;
  logic                     wr_v;
  logic [ptr_width_lp-1:0]  wr_idx;
  logic [vaddr_width_p-1:0] wr_data;

  // Checkpoint fields: {ptr, count, top_addr}
  logic [ptr_width_lp-1:0]  ckpt_ptr;
  logic [cnt_width_lp-1:0]  ckpt_cnt;
  logic [vaddr_width_p-1:0] ckpt_addr;

  logic [ptr_width_lp-1:0]  tos_inc;
  logic [ptr_width_lp-1:0]  tos_dec;
  logic                     empty;
  logic                     full;

  assign ckpt_ptr  = restore_ckpt_i[ckpt_width_lp-1 -: ptr_width_lp];
  assign ckpt_cnt  = restore_ckpt_i[vaddr_width_p+cnt_width_lp-1 -: cnt_width_lp];
  assign ckpt_addr = restore_ckpt_i[vaddr_width_p-1:0];

  // Pointer arithmetic wraps naturally because els_p is a power of two
  assign tos_inc = tos_r + ptr_width_lp'(1);
  assign tos_dec = tos_r - ptr_width_lp'(1);
  assign empty   = (count_r == '0);
  assign full    = (count_r == full_cnt_lp);

  // Next-state selection: restore > push&pop > push > pop
  always_comb begin
    tos_n       = tos_r;
    count_n     = count_r;
    overflow_n  = 1'b0;
    underflow_n = 1'b0;
    wr_v        = 1'b0;
    wr_idx      = tos_r;
    wr_data     = push_addr_i;

    if (restore_v_i) begin
      tos_n   = ckpt_ptr;
      count_n = ckpt_cnt;
      wr_v    = 1'b1;
      wr_idx  = ckpt_ptr;
      wr_data = ckpt_addr;
    end else if (push_i && pop_i && !empty) begin
      // Replace top in place
      wr_v   = 1'b1;
      wr_idx = tos_r;
    end else if (push_i) begin
      // Also covers push&pop on an empty stack
      tos_n  = tos_inc;
      wr_v   = 1'b1;
      wr_idx = tos_inc;
      if (full) begin
        overflow_n = 1'b1;
      end else begin
        count_n = count_r + cnt_width_lp'(1);
      end
    end else if (pop_i) begin
      if (empty) begin
        underflow_n = 1'b1;
      end else begin
        tos_n   = tos_dec;
        count_n = count_r - cnt_width_lp'(1);
      end
    end
  end

  // State and memory registers with asynchronous clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < els_p; i++) begin
        mem_r[i] <= '0;
      end
      tos_r       <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      tos_r       <= tos_n;
      count_r     <= count_n;
      overflow_r  <= overflow_n;
      underflow_r <= underflow_n;
      if (wr_v) begin
        mem_r[wr_idx] <= wr_data;
      end
    end
  end

  assign top_addr_o  = mem_r[tos_r];
  assign top_v_o     = !empty;
  assign count_o     = count_r;
  assign ckpt_o      = {tos_r, count_r, mem_r[tos_r]};
  assign overflow_o  = overflow_r;
  assign underflow_o = underflow_r;

endmodule
